// File: rtl/dma_pkg.sv
// Shared constants, register map and FSM encoding for the single-channel
// word-copy DMA engine.
package dma_pkg;

    localparam int DMA_LEN_W = 16;
    localparam logic [7:0] TIMEOUT = 8'd255;
    localparam logic [DMA_LEN_W-1:0] LEN_ONE = {{(DMA_LEN_W-1){1'b0}}, 1'b1};

    localparam logic READ  = 1'b1;
    localparam logic WRITE = 1'b0;

    localparam logic [1:0] REG_SRC  = 2'd0;
    localparam logic [1:0] REG_DST  = 2'd1;
    localparam logic [1:0] REG_LEN  = 2'd2;
    localparam logic [1:0] REG_CTRL = 2'd3;

    localparam int CTRL_BUSY = 0;
    localparam int CTRL_DONE = 1;
    localparam int CTRL_IE   = 2;
    localparam int CTRL_ERR  = 3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_RD_AS   = 3'd2,
        ST_RD_WAIT = 3'd3,
        ST_WR_AS   = 3'd4,
        ST_WR_WAIT = 3'd5,
        ST_NEXT    = 3'd6
    } dma_state_e;

endpackage

// File: rtl/dma_regs.sv
// CPU-facing register slave: decode, SRC/DST/LEN/CTRL storage and the IRQ level.
module dma_regs
    import dma_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_,
    input  logic                 CS_,
    input  logic                 As_,
    input  logic                 RW,
    input  logic [1:0]           Addr,
    input  logic [31:0]          WrData,
    output logic [31:0]          RdData,
    output logic                 Rdy_,
    output logic                 IRQ,
    input  logic                 step,
    input  logic                 finish,
    input  logic                 fail,
    output logic [29:0]          src,
    output logic [29:0]          dst,
    output logic [DMA_LEN_W-1:0] len,
    output logic                 busy
);

    logic [29:0]          src_q;
    logic [29:0]          dst_q;
    logic [DMA_LEN_W-1:0] len_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 err_q;
    logic                 ie_q;
    logic                 sel;
    logic                 wr;
    logic [31:0]          rd_val;
    logic                 wr_data_unused;

    assign sel = ~CS_ & ~As_;
    assign wr  = sel & (RW == WRITE);
    assign wr_data_unused = ^WrData[31:30];

    always_comb begin
        rd_val = '0;
        case (Addr)
            REG_SRC: rd_val = {2'b00, src_q};
            REG_DST: rd_val = {2'b00, dst_q};
            REG_LEN: rd_val = {{(32-DMA_LEN_W){1'b0}}, len_q};
            default: rd_val = {28'h0, err_q, ie_q, done_q, busy_q};
        endcase
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            RdData <= '0;
            Rdy_   <= 1'b1;
            src_q  <= '0;
            dst_q  <= '0;
            len_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            ie_q   <= 1'b0;
        end else begin
            RdData <= (sel && RW == READ) ? rd_val : '0;
            Rdy_   <= ~sel;

            if (step) begin
                src_q <= src_q + 30'd1;
                dst_q <= dst_q + 30'd1;
                len_q <= len_q - LEN_ONE;
            end else if (wr && !busy_q) begin
                case (Addr)
                    REG_SRC: src_q <= WrData[29:0];
                    REG_DST: dst_q <= WrData[29:0];
                    REG_LEN: len_q <= WrData[DMA_LEN_W-1:0];
                    default: ;
                endcase
            end

            if (wr && Addr == REG_CTRL) begin
                ie_q <= WrData[CTRL_IE];
                if (WrData[CTRL_DONE]) done_q <= 1'b0;
                if (WrData[CTRL_ERR])  err_q  <= 1'b0;
                // Start is only honoured when idle; a zero-length start completes at once.
                if (WrData[CTRL_BUSY] && !busy_q) begin
                    err_q <= 1'b0;
                    if (len_q == '0) begin
                        done_q <= 1'b1;
                    end else begin
                        busy_q <= 1'b1;
                        done_q <= 1'b0;
                    end
                end
            end

            // Completion outranks a same-cycle done clear.
            if (finish || fail) begin
                busy_q <= 1'b0;
                done_q <= 1'b1;
            end
            if (fail) err_q <= 1'b1;
        end
    end

    assign IRQ  = done_q & ie_q;
    assign src  = src_q;
    assign dst  = dst_q;
    assign len  = len_q;
    assign busy = busy_q;

endmodule

// File: rtl/dma_ctrl.sv
// Word-copy DMA top: bus-master sequencing with timeout, registers in dma_regs.
module dma_ctrl
    import dma_pkg::*;
(
    input  logic        clk,
    input  logic        reset_,
    input  logic        CS_,
    input  logic        As_,
    input  logic        RW,
    input  logic [1:0]  Addr,
    input  logic [31:0] WrData,
    output logic [31:0] RdData,
    output logic        Rdy_,
    output logic        MReq_,
    input  logic        MGrnt_,
    output logic [29:0] MAddr,
    output logic        MAs_,
    output logic        MRW,
    output logic [31:0] MWrData,
    input  logic [31:0] MRdData,
    input  logic        MRdy_,
    output logic        IRQ,
    output dma_state_e  fsm_state
);

    dma_state_e           state_q;
    dma_state_e           state_d;
    logic [7:0]           cnt_q;
    logic                 step;
    logic                 finish;
    logic                 fail;
    logic [29:0]          src;
    logic [29:0]          dst;
    logic [DMA_LEN_W-1:0] len;
    logic                 busy;

    dma_regs u_regs (
        .clk    (clk),
        .reset_ (reset_),
        .CS_    (CS_),
        .As_    (As_),
        .RW     (RW),
        .Addr   (Addr),
        .WrData (WrData),
        .RdData (RdData),
        .Rdy_   (Rdy_),
        .IRQ    (IRQ),
        .step   (step),
        .finish (finish),
        .fail   (fail),
        .src    (src),
        .dst    (dst),
        .len    (len),
        .busy   (busy)
    );

    always_comb begin
        state_d = state_q;
        step    = 1'b0;
        finish  = 1'b0;
        fail    = 1'b0;
        unique case (state_q)
            ST_IDLE:    if (busy) state_d = ST_REQ;
            ST_REQ:     if (!MGrnt_) state_d = ST_RD_AS;
            ST_RD_AS:   state_d = ST_RD_WAIT;
            ST_RD_WAIT: begin
                if (!MRdy_) begin
                    state_d = ST_WR_AS;
                end else if (cnt_q == TIMEOUT - 8'd1) begin
                    fail    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_WR_AS:   state_d = ST_WR_WAIT;
            ST_WR_WAIT: begin
                if (!MRdy_) begin
                    state_d = ST_NEXT;
                end else if (cnt_q == TIMEOUT - 8'd1) begin
                    fail    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_NEXT: begin
                step = 1'b1;
                if (len == LEN_ONE) begin
                    finish  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_REQ;
                end
            end
            default:    state_d = ST_IDLE;
        endcase
    end

    // Bus outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            MReq_   <= 1'b1;
            MAs_    <= 1'b1;
            MRW     <= READ;
            MAddr   <= '0;
            MWrData <= '0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q) cnt_q <= '0;
            else if (state_q == ST_RD_WAIT || state_q == ST_WR_WAIT) cnt_q <= cnt_q + 8'd1;

            MReq_ <= (state_d == ST_IDLE) || (state_d == ST_NEXT);
            MAs_  <= !((state_d == ST_RD_AS) || (state_d == ST_WR_AS));
            MRW   <= ((state_d == ST_WR_AS) || (state_d == ST_WR_WAIT)) ? WRITE : READ;
            if (state_d == ST_RD_AS)      MAddr <= src;
            else if (state_d == ST_WR_AS) MAddr <= dst;
            if (state_q == ST_RD_WAIT && !MRdy_) MWrData <= MRdData;
        end
    end

    assign fsm_state = state_q;

endmodule

// File: tb/tb_dma_ctrl.sv
// Bench for dma_ctrl: register driver, zero-wait memory model, scoreboard monitor.
module tb_dma_ctrl;
    import dma_pkg::*;

    logic        clk = 1'b0;
    logic        reset_;
    logic        CS_, As_, RW;
    logic [1:0]  Addr;
    logic [31:0] WrData;
    logic [31:0] RdData;
    logic        Rdy_;
    logic        MReq_;
    logic        MGrnt_;
    logic [29:0] MAddr;
    logic        MAs_;
    logic        MRW;
    logic [31:0] MWrData;
    logic [31:0] MRdData;
    logic        MRdy_;
    logic        IRQ;
    dma_state_e  fsm_state;

    int checks = 0;
    int failures = 0;
    int mreq_rel = 0;
    int mreq_low = 0;
    int rdwait_cnt = 0;
    logic mem_dead = 1'b0;

    logic [31:0] exp_q[$];
    string       name_q[$];
    logic [61:0] wr_exp_q[$];

    always #5 clk = ~clk;

    dma_ctrl dut (
        .clk(clk), .reset_(reset_), .CS_(CS_), .As_(As_), .RW(RW), .Addr(Addr),
        .WrData(WrData), .RdData(RdData), .Rdy_(Rdy_), .MReq_(MReq_), .MGrnt_(MGrnt_),
        .MAddr(MAddr), .MAs_(MAs_), .MRW(MRW), .MWrData(MWrData), .MRdData(MRdData),
        .MRdy_(MRdy_), .IRQ(IRQ), .fsm_state(fsm_state)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        CS_ = 1'b0; As_ = 1'b0; RW = 1'b0; Addr = a; WrData = d;
        exp_q.push_back(32'h0); name_q.push_back("write_rddata");
        @(posedge clk); #1;
        CS_ = 1'b1; As_ = 1'b1; RW = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] a, input logic [31:0] exp, input string nm);
        @(posedge clk); #1;
        CS_ = 1'b0; As_ = 1'b0; RW = 1'b1; Addr = a;
        exp_q.push_back(exp); name_q.push_back(nm);
        @(posedge clk); #1;
        CS_ = 1'b1; As_ = 1'b1;
        @(negedge clk); #1;
    endtask

    task automatic wait_done(input string nm);
        int n;
        n = 0;
        while (fsm_state == ST_IDLE && n < 10) begin @(negedge clk); n++; end
        n = 0;
        while (fsm_state != ST_IDLE && n < 2000) begin @(negedge clk); n++; end
        if (fsm_state != ST_IDLE) begin
            checks++; failures++;
            $display("FAIL %s wait expired: state=%0d required=IDLE", nm, fsm_state);
        end
    endtask

    // Memory slave: an address strobe seen in cycle n is answered in cycle n+1.
    initial begin
        logic        resp;
        logic [31:0] data;
        MRdy_ = 1'b1; MRdData = '0;
        forever begin
            @(negedge clk);
            resp = (MAs_ === 1'b0) && !mem_dead;
            data = (MRW === 1'b1) ? (32'hD000_0000 | {2'b00, MAddr}) : 32'h0;
            @(posedge clk); #1;
            MRdy_   = resp ? 1'b0 : 1'b1;
            MRdData = resp ? data : 32'h0;
        end
    end

    // Monitor: pops expectations whenever the DUT presents slave data or a master write.
    initial begin
        logic prev_mreq;
        prev_mreq = 1'b1;
        forever begin
            @(negedge clk);
            if (reset_ === 1'b1) begin
                if (MReq_ === 1'b0) mreq_low++;
                if (prev_mreq === 1'b0 && MReq_ === 1'b1) mreq_rel++;
                if (fsm_state == ST_RD_WAIT) rdwait_cnt++;
                if (Rdy_ === 1'b0) begin
                    if (exp_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL slave_rdy actual=Rdy_ low required=no access pending");
                    end else begin
                        check(name_q.pop_front(), {32'h0, RdData}, {32'h0, exp_q.pop_front()});
                    end
                end
                if (MAs_ === 1'b0 && MRW === 1'b0) begin
                    if (wr_exp_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL mwrite actual=addr %0h data %0h required=no write", MAddr, MWrData);
                    end else begin
                        check("mwrite", {2'b00, MAddr, MWrData}, {2'b00, wr_exp_q.pop_front()});
                    end
                end
            end
            prev_mreq = MReq_;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int bad;
        reset_ = 1'b0; CS_ = 1'b1; As_ = 1'b1; RW = 1'b1; Addr = '0; WrData = '0; MGrnt_ = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mreq", MReq_, 1'b1);
        check("rst_mas", MAs_, 1'b1);
        check("rst_maddr", MAddr, 30'h0);
        check("rst_irq", IRQ, 1'b0);
        reset_ = 1'b1;
        bus_read(REG_SRC, 32'h0, "rst_src");
        bus_read(REG_CTRL, 32'h0, "rst_ctrl");

        // Three-word copy.
        bus_write(REG_SRC, 32'h100);
        bus_write(REG_DST, 32'h200);
        bus_write(REG_LEN, 32'd3);
        wr_exp_q.push_back({30'h200, 32'hD000_0100});
        wr_exp_q.push_back({30'h201, 32'hD000_0101});
        wr_exp_q.push_back({30'h202, 32'hD000_0102});
        base = mreq_rel;
        bus_write(REG_CTRL, 32'h1);
        wait_done("copy3");
        check("copy3_releases", mreq_rel - base, 3);
        bus_read(REG_LEN, 32'h0, "copy3_len");
        bus_read(REG_SRC, 32'h103, "copy3_src");
        bus_read(REG_DST, 32'h203, "copy3_dst");
        bus_read(REG_CTRL, 32'h2, "copy3_ctrl");

        // Interrupt on completion, cleared by a done-clear write.
        bus_write(REG_SRC, 32'h300);
        bus_write(REG_DST, 32'h310);
        bus_write(REG_LEN, 32'd1);
        wr_exp_q.push_back({30'h310, 32'hD000_0300});
        bus_write(REG_CTRL, 32'h5);
        wait_done("irq_copy");
        check("irq_set", IRQ, 1'b1);
        bus_write(REG_CTRL, 32'h2);
        check("irq_clear", IRQ, 1'b0);
        bus_read(REG_CTRL, 32'h0, "irq_ctrl");

        // Grant withheld: request stays up, no strobe; config writes ignored while busy.
        MGrnt_ = 1'b1;
        bus_write(REG_SRC, 32'h500);
        bus_write(REG_DST, 32'h600);
        bus_write(REG_LEN, 32'd2);
        wr_exp_q.push_back({30'h600, 32'hD000_0500});
        wr_exp_q.push_back({30'h601, 32'hD000_0501});
        bus_write(REG_CTRL, 32'h1);
        bad = 0;
        while (MReq_ !== 1'b0 && bad < 10) begin @(negedge clk); bad++; end
        check("grant_req", MReq_, 1'b0);
        bus_write(REG_SRC, 32'h777);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (MAs_ !== 1'b1 || MReq_ !== 1'b0) bad++;
        end
        check("grant_hold", bad, 0);
        MGrnt_ = 1'b0;
        wait_done("grant_copy");
        bus_read(REG_SRC, 32'h502, "grant_src");
        bus_read(REG_CTRL, 32'h2, "grant_ctrl");

        // Read slave never answers: abort after the full timeout.
        mem_dead = 1'b1;
        bus_write(REG_SRC, 32'h40);
        bus_write(REG_DST, 32'h80);
        bus_write(REG_LEN, 32'd2);
        base = rdwait_cnt;
        bus_write(REG_CTRL, 32'h5);
        wait_done("timeout");
        check("timeout_cycles", rdwait_cnt - base, 255);
        check("timeout_mreq", MReq_, 1'b1);
        check("timeout_irq", IRQ, 1'b1);
        bus_read(REG_CTRL, 32'hE, "timeout_ctrl");
        bus_read(REG_SRC, 32'h40, "timeout_src");
        bus_read(REG_LEN, 32'd2, "timeout_len");
        mem_dead = 1'b0;
        bus_write(REG_CTRL, 32'hA);
        bus_read(REG_CTRL, 32'h0, "errclr_ctrl");

        // Source address wraps at the top of the word space.
        bus_write(REG_SRC, 32'h3FFF_FFFF);
        bus_write(REG_DST, 32'h10);
        wr_exp_q.push_back({30'h10, 32'hFFFF_FFFF});
        wr_exp_q.push_back({30'h11, 32'hD000_0000});
        bus_write(REG_CTRL, 32'h1);
        wait_done("wrap");
        bus_read(REG_SRC, 32'h1, "wrap_src");
        bus_read(REG_DST, 32'h12, "wrap_dst");

        // Asynchronous reset in the middle of the write phase.
        bus_write(REG_SRC, 32'h20);
        bus_write(REG_DST, 32'h30);
        bus_write(REG_LEN, 32'd1);
        wr_exp_q.push_back({30'h30, 32'hD000_0020});
        bus_write(REG_CTRL, 32'h1);
        bad = 0;
        while (fsm_state != ST_WR_WAIT && bad < 50) begin @(negedge clk); bad++; end
        check("reach_wr_wait", fsm_state, ST_WR_WAIT);
        #1 reset_ = 1'b0;
        #1;
        check("mid_rst_mreq", MReq_, 1'b1);
        check("mid_rst_mas", MAs_, 1'b1);
        check("mid_rst_mrw", MRW, 1'b1);
        check("mid_rst_maddr", MAddr, 30'h0);
        check("mid_rst_mwrdata", MWrData, 32'h0);
        check("mid_rst_state", fsm_state, ST_IDLE);
        @(negedge clk);
        reset_ = 1'b1;
        bus_read(REG_LEN, 32'h0, "post_rst_len");
        base = mreq_low;
        bus_write(REG_CTRL, 32'h1);
        repeat (5) @(negedge clk);
        bus_read(REG_CTRL, 32'h2, "len0_ctrl");
        check("len0_no_req", mreq_low - base, 0);

        repeat (5) @(negedge clk);
        check("slave_queue_drained", exp_q.size(), 0);
        check("write_queue_drained", wr_exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
